// File: rtl/regfile_dumper_if.sv
// Bus between the register-bank dumper and its host: control, bank read port and output stream.
// master = host side (drives commands, bank data, ready); slave = the dumper itself.
interface regfile_dumper_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, first_addr, last_addr, read_data, out_ready,
    input  read_addr, out_valid, out_addr, out_data, busy, done
  );

  modport slave (
    input  start, abort, first_addr, last_addr, read_data, out_ready,
    output read_addr, out_valid, out_addr, out_data, busy, done
  );
endinterface

// File: rtl/regfile_dumper.sv
// Walks an inclusive register range through one async read port and streams
// (address, data) beats over valid/ready; all outputs registered.
module regfile_dumper #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_dumper_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur           <= '0;
      last          <= '0;
      bus.read_addr <= '0;
      bus.out_valid <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_data  <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state != IDLE && bus.abort) begin
        // Abort wins over everything, including a same-cycle handshake
        state         <= IDLE;
        bus.out_valid <= 1'b0;
        bus.busy      <= 1'b0;
        bus.read_addr <= '0;
      end else begin
        case (state)
          IDLE: begin
            bus.read_addr <= '0;
            if (bus.start) begin
              cur  <= bus.first_addr;
              last <= bus.last_addr;
              if (bus.first_addr > bus.last_addr) begin
                state    <= DONE;
                bus.done <= 1'b1;
              end else begin
                state         <= READ;
                bus.busy      <= 1'b1;
                bus.read_addr <= bus.first_addr;
              end
            end
          end
          READ: begin
            bus.out_data  <= bus.read_data;
            bus.out_addr  <= cur;
            bus.out_valid <= 1'b1;
            state         <= SEND;
          end
          SEND: begin
            if (bus.out_ready) begin
              bus.out_valid <= 1'b0;
              // Compare before increment so last==max never wraps cur
              if (cur == last) begin
                state         <= DONE;
                bus.busy      <= 1'b0;
                bus.done      <= 1'b1;
                bus.read_addr <= '0;
              end else begin
                cur           <= cur + ADDR_W'(1);
                bus.read_addr <= cur + ADDR_W'(1);
                state         <= READ;
              end
            end
          end
          DONE: begin
            state         <= IDLE;
            bus.read_addr <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: directed dumps push expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_regfile_dumper;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_dumper_if #(.ADDR_W(5), .DATA_W(32)) dif ();

  regfile_dumper #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  logic [31:0] bank [32];
  assign dif.read_data = bank[dif.read_addr];

  beat_t exp_q [$];
  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int last_hs = -1;
  int first_hs = -1;
  int done_seen = 0;
  int done_cyc = -1;
  int start_cyc = 0;
  bit gap_check = 1'b0;
  int rmode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input int a);
    beat_t b;
    b.a = 5'(a);
    b.d = {4{8'(a)}};
    return b;
  endfunction

  task automatic push_range(input int f, input int l);
    for (int a = f; a <= l; a++) exp_q.push_back(mk(a));
  endtask

  task automatic start_dump(input int f, input int l);
    @(posedge clk); #1;
    start_cyc = cyc;
    dif.start = 1'b1;
    dif.first_addr = 5'(f);
    dif.last_addr = 5'(l);
    @(posedge clk); #1;
    dif.start = 1'b0;
  endtask

  task automatic wait_drain(input string n, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || dif.busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({n, "_drain_timeout"}, longint'(k < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_beat(input int a, input int budget);
    int k = 0;
    while (!(dif.out_valid && dif.out_addr == 5'(a)) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_beat_timeout", longint'(k < budget), 1);
  endtask

  // Ready driver: mode 0 always ready, mode 1 stalls 3 cycles per beat
  initial begin
    int cnt = 0;
    dif.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rmode == 0) dif.out_ready = 1'b1;
      else if (dif.out_valid) begin
        if (cnt == 3) begin dif.out_ready = 1'b1; cnt = 0; end
        else begin dif.out_ready = 1'b0; cnt++; end
      end else dif.out_ready = 1'b0;
    end
  end

  // Monitor: stability while stalled, beat scoreboard, done tracking
  initial begin
    bit held_v = 1'b0;
    beat_t held;
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (held_v && dif.out_valid) begin
          chk("stall_addr", longint'(dif.out_addr), longint'(held.a));
          chk("stall_data", longint'(dif.out_data), longint'(held.d));
        end
        if (dif.out_valid && dif.out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_beat: got addr %0d data 0x%0h, none expected", dif.out_addr, dif.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_addr", longint'(dif.out_addr), longint'(e.a));
            chk("beat_data", longint'(dif.out_data), longint'(e.d));
            if (gap_check && last_hs >= 0) chk("beat_gap", longint'(cyc - last_hs), 2);
            if (last_hs < 0) first_hs = cyc;
            last_hs = cyc;
          end
        end
        held_v = dif.out_valid && !dif.out_ready;
        held.a = dif.out_addr;
        held.d = dif.out_data;
        if (dif.done) begin
          done_seen++;
          done_cyc = cyc;
        end
      end else held_v = 1'b0;
    end
  end

  initial begin
    int d0;
    for (int i = 0; i < 32; i++) bank[i] = 32'(i) * 32'h0101_0101;
    dif.start = 1'b0;
    dif.abort = 1'b0;
    dif.first_addr = '0;
    dif.last_addr = '0;

    repeat (2) @(posedge clk); #1;
    chk("rst_valid", longint'(dif.out_valid), 0);
    chk("rst_busy", longint'(dif.busy), 0);
    chk("rst_done", longint'(dif.done), 0);
    chk("rst_raddr", longint'(dif.read_addr), 0);
    chk("rst_oaddr", longint'(dif.out_addr), 0);
    chk("rst_odata", longint'(dif.out_data), 0);
    rst_n = 1'b1;

    // Full range, always ready
    d0 = done_seen; last_hs = -1; gap_check = 1'b1;
    push_range(0, 31);
    start_dump(0, 31);
    wait_drain("full", 200);
    gap_check = 1'b0;
    chk("full_first_lat", longint'(first_hs - start_cyc), 2);
    chk("full_done_cnt", longint'(done_seen - d0), 1);
    chk("full_done_lat", longint'(done_cyc - last_hs), 1);
    chk("full_busy_after", longint'(dif.busy), 0);
    repeat (5) @(negedge clk);
    chk("full_no_wrap_valid", longint'(dif.out_valid), 0);

    // 5..7 with 3-cycle stalls; bank write during SEND must not leak
    rmode = 1; d0 = done_seen; last_hs = -1;
    push_range(5, 7);
    start_dump(5, 7);
    wait_beat(6, 50);
    bank[6] = 32'hDEAD_BEEF;
    wait_drain("stall", 100);
    bank[6] = 32'h0606_0606;
    rmode = 0;
    chk("stall_done_cnt", longint'(done_seen - d0), 1);

    // Single register
    d0 = done_seen; last_hs = -1;
    push_range(9, 9);
    start_dump(9, 9);
    wait_drain("single", 50);
    chk("single_done_cnt", longint'(done_seen - d0), 1);
    chk("single_done_lat", longint'(done_cyc - last_hs), 1);

    // Empty range
    d0 = done_seen;
    start_dump(20, 3);
    repeat (4) @(negedge clk);
    chk("empty_done_cnt", longint'(done_seen - d0), 1);
    chk("empty_done_lat", longint'(done_cyc - start_cyc), 1);

    // Abort during SEND of beat 4 (same-cycle handshake still delivers it)
    d0 = done_seen; last_hs = -1;
    push_range(0, 4);
    start_dump(0, 31);
    wait_beat(4, 50);
    dif.abort = 1'b1;
    @(posedge clk); #1;
    dif.abort = 1'b0;
    chk("abort_valid", longint'(dif.out_valid), 0);
    chk("abort_busy", longint'(dif.busy), 0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", longint'(done_seen - d0), 0);
    chk("abort_q_empty", longint'(exp_q.size()), 0);
    d0 = done_seen; last_hs = -1;
    push_range(0, 1);
    start_dump(0, 1);
    wait_drain("restart", 50);
    chk("restart_done_cnt", longint'(done_seen - d0), 1);

    // Start while busy is ignored
    d0 = done_seen; last_hs = -1;
    push_range(10, 12);
    start_dump(10, 12);
    start_dump(0, 31);
    wait_drain("busy_start", 60);
    repeat (4) @(negedge clk);
    chk("busy_start_done_cnt", longint'(done_seen - d0), 1);
    chk("busy_start_valid", longint'(dif.out_valid), 0);

    // Reset during beat 10
    d0 = done_seen; last_hs = -1;
    push_range(0, 9);
    start_dump(0, 31);
    wait_beat(10, 60);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_valid", longint'(dif.out_valid), 0);
    chk("mrst_busy", longint'(dif.busy), 0);
    chk("mrst_done", longint'(dif.done), 0);
    chk("mrst_raddr", longint'(dif.read_addr), 0);
    chk("mrst_oaddr", longint'(dif.out_addr), 0);
    chk("mrst_odata", longint'(dif.out_data), 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mrst_idle_valid", longint'(dif.out_valid), 0);
    chk("mrst_no_done", longint'(done_seen - d0), 0);
    chk("mrst_q_empty", longint'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dumper.md
Name: regfile_dumper

Overview:
- Sequential reader for the 32x32 register bank. On Start it walks an address range through one asynchronous read port and streams each (address, data) pair out over a valid/ready handshake.
- Used by the top level for debug dump, display and checkers.
- Owns its read port: ReadAddr drives the bank's ReadAddr input; ReadData comes from the matching ReadData output.

Parameters:
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset; sampled only on the rising edge of Clock.
- Start  in  1  begin a dump; honoured only in IDLE.
- Abort  in  1  cancel the dump in progress; honoured in any non-IDLE state.
- FirstAddr  in  ADDR_W  first register of the range; latched on an accepted Start.
- LastAddr  in  ADDR_W  last register of the range, inclusive; latched on an accepted Start.
- ReadAddr  out  ADDR_W  address to the bank's read port.
- ReadData  in  DATA_W  asynchronous read data from the bank.
- OutValid  out  1  OutAddr/OutData hold a beat.
- OutReady  in  1  consumer accepts the beat.
- OutAddr  out  ADDR_W  register number of the current beat.
- OutData  out  DATA_W  register contents of the current beat.
- Busy  out  1  high in READ and SEND.
- Done  out  1  one-cycle pulse when a dump completes normally.

Behaviour:
- Reset (Reset=0 at an edge): state=IDLE; cur, first and last cleared to 0; ReadAddr, OutValid, OutAddr, OutData, Busy and Done all 0. Reset overrides Start and Abort and kills any dump in progress. No Done is produced and no partial beat is left behind.
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - ReadAddr=0.
  - Start=1: latch first=FirstAddr, last=LastAddr, cur=FirstAddr.
  - If FirstAddr>LastAddr (unsigned): empty range, go to DONE with zero beats. Otherwise go to READ.
- READ (one cycle):
  - ReadAddr=cur.
  - At the edge: OutData<=ReadData, OutAddr<=cur, OutValid<=1, go to SEND.
- SEND:
  - ReadAddr holds cur.
  - OutValid=1. OutAddr and OutData stay stable until the handshake completes.
  - Handshake = OutValid&&OutReady at an edge:
    - If cur==last: OutValid<=0, go to DONE.
    - Else: cur<=cur+1, OutValid<=0, go to READ.
  - The compare happens before the increment, so last=31 never wraps cur to 0.
- DONE: Done=1 for exactly one cycle, Busy=0, then IDLE.
- Abort=1 in READ, SEND or DONE: next state IDLE, OutValid<=0, no Done. If Abort and a handshake occur in the same cycle, the beat counts as delivered and the abort still wins.
- Start outside IDLE is ignored. Start and Abort together in IDLE: the Start is accepted.
- Throughput: at most one beat per 2 cycles. Latency from accepted Start to first OutValid is 2 edges.
- Beats are emitted in strictly increasing address order. Register 0 is included and its data is whatever the bank returns.
- ReadData is sampled only at the READ edge. A bank write to cur during SEND does not change the beat already presented.

Test Plan:
- Preload bank reg i = i*0x01010101. Start with First=0, Last=31 and OutReady=1 -> 32 beats, OutAddr 0..31, OutData matching, beats 2 cycles apart. Done pulses once, one cycle after beat 31. Busy then low.
- First=5, Last=7; OutReady low for 3 cycles on each beat -> exactly 3 beats (5, 6, 7). OutAddr/OutData are stable while stalled and no beat is duplicated.
- First=9, Last=9 -> one beat (addr 9, data 0x09090909), then Done. First=20, Last=3 -> no OutValid, and Done is asserted 1 cycle after Start.
- Range 0..31; assert Abort during the SEND of beat 4 -> OutValid low at the next edge, no Done. A new Start 0..1 afterwards gives 2 correct beats.
- Pulse Start again while Busy -> ignored: the range and sequence are unchanged.
- Drive Reset=0 for 1 cycle during beat 10 -> all outputs 0 at the next edge, no Done, state IDLE.
- Full range with First=0, Last=31 -> cur never wraps, and no beat is issued for addr 0 after beat 31.
